// File: rtl/pmod_debounce_ch.sv
// One PMOD input channel: two-flop synchroniser, persistence counter, debounced level
// and registered rise/fall strobes.
module pmod_debounce_ch #(
    parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
    input  logic clk48,
    input  logic rst,
    input  logic pin_in,
    output logic level,
    output logic level_next,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Plain flop pair so the first stage may go metastable without feeding logic.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pin_in;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            level_d = s2_q;
            cnt_d   = '0;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level      = level_q;
    assign level_next = level_d;
    assign rise       = rise_q;
    assign fall       = fall_q;

endmodule

// File: rtl/pmod_in_debounce.sv
// Debounced PMOD input block: N channels plus a valid/ready change-event stream that
// coalesces changes while the consumer stalls and flags lost transitions as overrun.
module pmod_in_debounce #(
    parameter int unsigned N               = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
    input  logic         clk48,
    input  logic         rst,
    input  logic [N-1:0] pin_in,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         evt_valid,
    input  logic         evt_ready,
    output logic [N-1:0] evt_mask,
    output logic [N-1:0] evt_level,
    output logic         overrun,
    input  logic         overrun_clr
);

    logic [N-1:0] level_next;
    logic [N-1:0] chg;
    logic [N-1:0] load;
    logic         slot_free;
    logic         ovr_set;

    logic         evt_valid_q, evt_valid_d;
    logic [N-1:0] evt_mask_q, evt_mask_d;
    logic [N-1:0] evt_level_q, evt_level_d;
    logic [N-1:0] pending_q, pending_d;
    logic         overrun_q, overrun_d;

    for (genvar i = 0; i < N; i++) begin : g_ch
        pmod_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk48     (clk48),
            .rst       (rst),
            .pin_in    (pin_in[i]),
            .level     (level[i]),
            .level_next(level_next[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

    assign chg       = rise | fall;
    assign slot_free = ~evt_valid_q | evt_ready;
    assign load      = pending_q | chg;
    // A change on a bit already waiting (queued or on the output) loses a transition.
    assign ovr_set   = ~slot_free & (|(chg & (pending_q | evt_mask_q)));

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_mask_d  = evt_mask_q;
        evt_level_d = evt_level_q;
        pending_d   = pending_q;
        if (slot_free) begin
            if (|load) begin
                evt_valid_d = 1'b1;
                evt_mask_d  = load;
                evt_level_d = level_next;
                pending_d   = '0;
            end else begin
                evt_valid_d = 1'b0;
            end
        end else begin
            pending_d = pending_q | chg;
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_mask_q  <= '0;
            evt_level_q <= '0;
            pending_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_mask_q  <= evt_mask_d;
            evt_level_q <= evt_level_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_mask  = evt_mask_q;
    assign evt_level = evt_level_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/pmod_in_debounce.md
Name: pmod_in_debounce

Overview:
- Input-side companion to the board's LED/PMOD output drivers. Samples up to eight PMOD header pins as inputs, synchronises each pin to clk48, and debounces it.
- Produces a clean level, one-cycle rise and fall strobes, and a valid/ready change-event stream for a consumer such as a UART reporter or a CPU register bridge.
- Sits directly behind the top-level PMOD pins.

Parameters:
- N, 8, number of input channels (1..8).
- DEBOUNCE_CYCLES, 48000, cycles a new synchronised level must persist before it is accepted (1 ms at 48 MHz); must be >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the per-channel debounce counter; derived, not overridden.

Ports:
- clk48  input  1  system clock, 48 MHz.
- rst  input  1  asynchronous reset, active-high.
- pin_in  input  N  raw PMOD pins, asynchronous to clk48.
- level  output  N  debounced level per channel.
- rise  output  N  one-cycle strobe when level goes 0->1.
- fall  output  N  one-cycle strobe when level goes 1->0.
- evt_valid  output  1  change event available.
- evt_ready  input  1  consumer accepts the event.
- evt_mask  output  N  channels that changed since the last accepted event.
- evt_level  output  N  snapshot of level when evt_mask was loaded.
- overrun  output  1  sticky flag: a channel changed twice before it was reported.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Clock and reset: one clock, clk48. rst is asynchronous and active-high. All flops clear on rst assertion and release synchronously with clk48.
- Reset values: sync flops 0, level 0, rise 0, fall 0, counters 0, evt_valid 0, evt_mask 0, evt_level 0, pending 0, overrun 0.
- Synchroniser: two flops per channel (s1 <= pin_in, s2 <= s1). No logic sits between the two flops.
- Debounce, per channel i, every cycle:
  - If s2[i] == level[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: level[i] <= s2[i] and cnt[i] <= 0. rise[i]/fall[i] assert for exactly this one following cycle.
  - Else: cnt[i] <= cnt[i]+1.
  - Any return of s2 to level before the count completes restarts the count. Glitches shorter than DEBOUNCE_CYCLES cycles never reach level.
- Latency: for a pin held at a new value, level updates DEBOUNCE_CYCLES+2 clk48 edges after the first edge that samples the new value. rise/fall are registered and coincide with the level update.
- Change vector: chg = rise | fall.
- Event path, with pending as an internal N-bit accumulator:
  - If evt_valid=0 or evt_ready=1 (slot free or being emptied this cycle):
    - load = pending | chg.
    - If load != 0: evt_mask <= load, evt_level <= next level value, evt_valid <= 1, pending <= 0.
    - Otherwise evt_valid <= 0.
  - Else (stalled): evt_mask and evt_level hold unchanged, and pending <= pending | chg.
- Handshake:
  - Transfer occurs on the cycle where evt_valid && evt_ready.
  - evt_mask and evt_level are stable while evt_valid && !evt_ready.
  - evt_valid never drops without a transfer.
  - With evt_ready tied high, each change appears one cycle after its strobe.
- Overrun:
  - Set when chg[i] && pending[i] while stalled.
  - Set when chg[i] && evt_mask[i] && evt_valid && !evt_ready.
  - The second change is still recorded: level tracks it and the bit stays set.
  - overrun_clr clears overrun unless a new overrun condition occurs the same cycle; set wins.
- Simultaneous changes on several channels in one cycle are reported together in a single event.
- Reset mid-debounce discards the partial count. After release, level starts at 0, and a pin held high produces a rise after DEBOUNCE_CYCLES+2 edges.
- Counter width never overflows: cnt is bounded by DEBOUNCE_CYCLES-1.

Decomposition:
- No shared package needed.
- Sub-module pmod_debounce_ch holds one channel's synchroniser, counter, level, rise and fall. It is instantiated N times in a generate loop.
- The event and overrun logic stays in the top module.

Test Plan (run with DEBOUNCE_CYCLES=4, N=8, evt_ready=1 unless stated):
- Reset: assert rst asynchronously mid-cycle with pin_in=8'hFF -> all outputs 0 immediately. After release, level=8'hFF and rise=8'hFF for one cycle exactly 6 edges later; one event with evt_mask=8'hFF, evt_level=8'hFF.
- Glitch rejection: pulse pin_in[0] high for 3 cycles, then low -> no rise, level[0]=0, evt_valid never asserts. A 4-cycle-plus pulse gives rise[0] at edge 6 and fall[0] 6 edges after release.
- Multi-channel: pin_in goes 8'h00->8'h05 in one cycle -> rise=8'h05 for one cycle; single event evt_mask=8'h05, evt_level=8'h05.
- Backpressure: evt_ready=0 throughout. Channel 1 rises (evt_mask=8'h02 held), then channel 3 rises -> evt_mask stays 8'h02. Raise ready for one cycle -> next event evt_mask=8'h08, evt_level=8'h0A.
- Overrun: ready=0, channel 2 rises then falls while unreported -> overrun=1, evt_mask=8'h04 held. Pulse overrun_clr -> overrun=0 next cycle. overrun_clr coinciding with a new overrun condition -> overrun stays 1.
- Boundary DEBOUNCE_CYCLES=1 (separate build): a pin step reaches level 3 edges after sampling, and a 1-cycle glitch is accepted as a level change.
